// File: rtl/juggle_pkg.sv
// Shared definitions for the siteswap pattern scheduler: limits, FSM states,
// landing-schedule entry type and a small modulo helper used by the validator.
package juggle_pkg;

    localparam int MAX_PATTERN_LEN = 7;
    localparam int MAX_HEIGHT      = 7;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } land_t;

    // v <= 13 and m >= 1 in practice; eight conditional subtractions cover the
    // worst case (m = 1, v = 7).
    function automatic logic [2:0] mod_small(input logic [3:0] v, input logic [2:0] m);
        logic [3:0] r;
        r = v;
        for (int k = 0; k < 8; k++) begin
            if (r >= {1'b0, m}) r = r - {1'b0, m};
        end
        return r[2:0];
    endfunction

endpackage

// File: rtl/validate_pattern.sv
// Combinational siteswap check: a pattern is valid when every throw position
// i lands on a distinct beat (i + slot[i]) mod length.
module validate_pattern
    import juggle_pkg::*;
(
    input  logic [MAX_PATTERN_LEN-1:0][2:0] slots,
    input  logic [2:0]                      length,
    output logic                            valid
);

    logic [7:0] hit;
    logic [2:0] land;
    logic       ok;

    always_comb begin
        hit  = '0;
        land = '0;
        ok   = (length != 3'd0);
        for (int i = 0; i < MAX_PATTERN_LEN; i++) begin
            land = mod_small({1'b0, 3'(i)} + {1'b0, slots[i]}, length);
            if (3'(i) < length) begin
                if (hit[land]) ok = 1'b0;
                hit[land] = 1'b1;
            end
        end
        valid = ok;
    end

endmodule

// File: rtl/pattern_scheduler.sv
// Loads a siteswap pattern digit by digit, validates it, then plays it one
// throw per beat while tracking which ball lands on each future beat.
module pattern_scheduler
    import juggle_pkg::*;
#(
    parameter int BEAT_PERIOD = 25_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [2:0] digit_in,
    input  logic       digit_valid_in,
    output logic       digit_ready_out,
    input  logic       commit_in,
    input  logic       clear_in,
    output logic [2:0] pattern_length_out,
    output logic       running_out,
    output logic       error_out,
    output logic       throw_valid_out,
    output logic [2:0] throw_height_out,
    output logic [2:0] throw_ball_out,
    output logic [2:0] throw_index_out
);

    localparam int CW = (BEAT_PERIOD > 1) ? $clog2(BEAT_PERIOD) : 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_PERIOD - 1);

    state_t                             state;
    logic [2:0]                         length;
    logic [MAX_PATTERN_LEN-1:0][2:0]    slots;
    logic [MAX_PATTERN_LEN-1:0][2:0]    slots_masked;
    land_t [MAX_HEIGHT-1:0]             sched;
    land_t [MAX_HEIGHT-1:0]             sched_nxt;
    logic [2:0]                         next_id;
    logic [2:0]                         id_nxt;
    logic [2:0]                         index;
    logic [2:0]                         index_nxt;
    logic [CW-1:0]                      beat_cnt;
    logic [2:0]                         cur_h;
    logic [2:0]                         cur_ball;
    logic                               accept;
    logic [2:0]                         len_nxt;
    logic                               pattern_ok;

    assign digit_ready_out    = (state == ST_LOAD) && (length < 3'd7);
    assign accept             = digit_valid_in && digit_ready_out;
    assign len_nxt            = length + {2'b00, accept};
    assign pattern_length_out = length;
    assign running_out        = (state == ST_RUN);
    assign error_out          = (state == ST_ERROR);

    // Stale digits from an earlier, longer pattern must not reach the validator.
    always_comb begin
        for (int i = 0; i < MAX_PATTERN_LEN; i++) begin
            slots_masked[i] = (3'(i) < length) ? slots[i] : 3'd0;
        end
    end

    validate_pattern u_validate (
        .slots  (slots_masked),
        .length (length),
        .valid  (pattern_ok)
    );

    assign cur_h     = slots[index];
    assign index_nxt = (index == length - 3'd1) ? 3'd0 : index + 3'd1;

    // Shift the landing schedule by one beat, then park the thrown ball h-1
    // entries ahead (it lands h beats from now).
    always_comb begin
        for (int i = 0; i < MAX_HEIGHT - 1; i++) begin
            sched_nxt[i] = sched[i + 1];
        end
        sched_nxt[MAX_HEIGHT-1] = '0;
        cur_ball = 3'd0;
        id_nxt   = next_id;
        if (cur_h != 3'd0) begin
            if (sched[0].valid) begin
                cur_ball = sched[0].id;
            end else begin
                cur_ball = next_id;
                id_nxt   = next_id + 3'd1;
            end
            for (int i = 0; i < MAX_HEIGHT; i++) begin
                if (3'(i) == cur_h - 3'd1) sched_nxt[i] = '{valid: 1'b1, id: cur_ball};
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= ST_LOAD;
            length           <= '0;
            slots            <= '0;
            sched            <= '0;
            next_id          <= 3'd1;
            index            <= '0;
            beat_cnt         <= '0;
            throw_valid_out  <= 1'b0;
            throw_height_out <= '0;
            throw_ball_out   <= '0;
            throw_index_out  <= '0;
        end else begin
            throw_valid_out <= 1'b0;
            if (clear_in) begin
                state            <= ST_LOAD;
                length           <= '0;
                slots            <= '0;
                sched            <= '0;
                next_id          <= 3'd1;
                index            <= '0;
                beat_cnt         <= '0;
                throw_height_out <= '0;
                throw_ball_out   <= '0;
                throw_index_out  <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (accept) begin
                            for (int i = 0; i < MAX_PATTERN_LEN; i++) begin
                                if (3'(i) == length) slots[i] <= digit_in;
                            end
                        end
                        length <= len_nxt;
                        if (commit_in) state <= (len_nxt == 3'd0) ? ST_ERROR : ST_CHECK;
                    end
                    ST_CHECK: begin
                        beat_cnt <= '0;
                        index    <= '0;
                        state    <= pattern_ok ? ST_RUN : ST_ERROR;
                    end
                    ST_RUN: begin
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt         <= '0;
                            throw_valid_out  <= 1'b1;
                            throw_height_out <= cur_h;
                            throw_ball_out   <= cur_ball;
                            throw_index_out  <= index;
                            sched            <= sched_nxt;
                            next_id          <= id_nxt;
                            index            <= index_nxt;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                    ST_ERROR: ;
                    default: state <= ST_LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench: randomized loads and patterns against an absolute-time
// landing model of siteswap juggling.
module tb_pattern_scheduler;

    localparam int BP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] digit = '0;
    logic       digit_valid = 1'b0;
    logic       ready;
    logic       commit = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] plen;
    logic       running;
    logic       error;
    logic       tvalid;
    logic [2:0] theight;
    logic [2:0] tball;
    logic [2:0] tindex;

    int n_cmp = 0;
    int n_bad = 0;
    int pat[$];

    pattern_scheduler #(.BEAT_PERIOD(BP)) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .digit_in           (digit),
        .digit_valid_in     (digit_valid),
        .digit_ready_out    (ready),
        .commit_in          (commit),
        .clear_in           (clear),
        .pattern_length_out (plen),
        .running_out        (running),
        .error_out          (error),
        .throw_valid_out    (tvalid),
        .throw_height_out   (theight),
        .throw_ball_out     (tball),
        .throw_index_out    (tindex)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Siteswap rule: positions i land on beats (i + d_i) mod n, all distinct.
    function automatic bit model_valid();
        bit seen[8];
        int n;
        n = pat.size();
        if (n == 0) return 1'b0;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        for (int i = 0; i < n; i++) begin
            int l;
            l = (i + pat[i]) % n;
            if (seen[l]) return 1'b0;
            seen[l] = 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic load_pattern();
        foreach (pat[i]) begin
            while ($urandom_range(0, 2) == 0) begin
                digit_valid = 1'b0;
                digit = 3'($urandom);
                step();
            end
            n_cmp++;
            if (ready !== 1'b1) begin
                n_bad++;
                $display("FAIL load_ready: got %0b want 1", ready);
            end
            digit_valid = 1'b1;
            digit = 3'(pat[i]);
            step();
        end
        digit_valid = 1'b0;
        n_cmp++;
        if (plen !== 3'(pat.size())) begin
            n_bad++;
            $display("FAIL load_length: got %0d want %0d", plen, pat.size());
        end
    endtask

    task automatic commit_and_check(output bit ok);
        ok = model_valid();
        commit = 1'b1;
        step();
        commit = 1'b0;
        n_cmp++;
        if ({running, error, ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL check_state: run/err/rdy got %b want 000", {running, error, ready});
        end
        step();
        n_cmp++;
        if ({running, error} !== {ok, !ok}) begin
            n_bad++;
            $display("FAIL verdict: run/err got %b want %b", {running, error}, {ok, !ok});
        end
    endtask

    // Balls are tracked by the absolute beat on which they come down.
    task automatic run_beats(input int nbeats, output int nballs);
        int land_at[int];
        int next_id;
        int n;
        int eh, eb, ei;
        bit pulsed;
        bit used[8];
        next_id = 1;
        n = pat.size();
        eh = 0; eb = 0; ei = 0;
        pulsed = 1'b0;
        nballs = 0;
        for (int i = 0; i < 8; i++) used[i] = 1'b0;
        for (int t = 0; t < nbeats; t++) begin
            for (int c = 1; c <= BP; c++) begin
                step();
                n_cmp++;
                if (tvalid !== (c == BP)) begin
                    n_bad++;
                    $display("FAIL pulse_timing: beat %0d cyc %0d got %0b want %0b", t, c, tvalid, c == BP);
                end
                if (c == BP) begin
                    eh = pat[t % n];
                    ei = t % n;
                    eb = 0;
                    if (eh > 0) begin
                        if (land_at.exists(t)) eb = land_at[t];
                        else begin
                            eb = next_id;
                            next_id++;
                        end
                        land_at[t + eh] = eb;
                        if (eb < 8 && !used[eb]) begin
                            used[eb] = 1'b1;
                            nballs++;
                        end
                    end
                    pulsed = 1'b1;
                end
                if (pulsed) begin
                    n_cmp++;
                    if ({theight, tball, tindex} !== {3'(eh), 3'(eb), 3'(ei)}) begin
                        n_bad++;
                        $display("FAIL throw: beat %0d cyc %0d h/ball/idx got %0d/%0d/%0d want %0d/%0d/%0d",
                                 t, c, theight, tball, tindex, eh, eb, ei);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ready, running, error, tvalid, plen, theight, tball, tindex} !== {4'b1000, 12'd0}) begin
            n_bad++;
            $display("FAIL reset: rdy/run/err/tv=%b len=%0d h=%0d b=%0d i=%0d",
                     {ready, running, error, tvalid}, plen, theight, tball, tindex);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fixed(input int a[$], input int beats, input int want_balls);
        bit ok;
        int nb;
        pat = a;
        load_pattern();
        commit_and_check(ok);
        if (ok) begin
            run_beats(beats, nb);
            n_cmp++;
            if (nb != want_balls) begin
                n_bad++;
                $display("FAIL ball_count: got %0d want %0d", nb, want_balls);
            end
        end
        do_clear();
    endtask

    task automatic test_error_pattern();
        bit ok;
        pat = '{3, 2, 1};
        load_pattern();
        commit_and_check(ok);
        for (int c = 0; c < 3 * BP; c++) begin
            step();
            n_cmp++;
            if ({tvalid, error} !== 2'b01) begin
                n_bad++;
                $display("FAIL error_hold: tv/err got %b want 01", {tvalid, error});
            end
        end
        do_clear();
        n_cmp++;
        if ({ready, error, plen} !== {2'b10, 3'd0}) begin
            n_bad++;
            $display("FAIL clear_after_error: rdy/err got %b len %0d", {ready, error}, plen);
        end
    endtask

    task automatic test_boundaries();
        // empty commit goes straight to ERROR
        commit = 1'b1;
        step();
        commit = 1'b0;
        n_cmp++;
        if ({running, error} !== 2'b01) begin
            n_bad++;
            $display("FAIL empty_commit: run/err got %b want 01", {running, error});
        end
        do_clear();
        // full pattern then an eighth digit
        pat = '{7, 1, 2, 3, 4, 5, 6};
        load_pattern();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready: got %0b want 0", ready);
        end
        digit_valid = 1'b1;
        digit = 3'd5;
        step();
        digit_valid = 1'b0;
        n_cmp++;
        if (plen !== 3'd7) begin
            n_bad++;
            $display("FAIL full_length: got %0d want 7", plen);
        end
        do_clear();
        // clear wins over commit in the same cycle
        pat = '{3};
        load_pattern();
        commit = 1'b1;
        clear = 1'b1;
        step();
        commit = 1'b0;
        clear = 1'b0;
        step();
        n_cmp++;
        if ({ready, running, error, plen} !== {3'b100, 3'd0}) begin
            n_bad++;
            $display("FAIL clear_vs_commit: rdy/run/err %b len %0d", {ready, running, error}, plen);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int nb;
        pat = '{5, 3, 1};
        load_pattern();
        commit_and_check(ok);
        run_beats(1, nb);
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({ready, running, error, tvalid, plen, theight, tball, tindex} !== {4'b1000, 12'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_run: rdy/run/err/tv=%b len=%0d h=%0d b=%0d i=%0d",
                     {ready, running, error, tvalid}, plen, theight, tball, tindex);
        end
        rst = 1'b0;
        for (int c = 0; c < 3 * BP; c++) begin
            step();
            n_cmp++;
            if ({tvalid, running} !== 2'b00) begin
                n_bad++;
                $display("FAIL post_reset_pulse: tv/run got %b want 00", {tvalid, running});
            end
        end
    endtask

    task automatic test_random();
        for (int trial = 0; trial < 16; trial++) begin
            int n;
            int perm[7];
            bit ok;
            int nb;
            n = $urandom_range(1, 7);
            pat = {};
            if (trial % 2 == 0) begin
                for (int i = 0; i < 7; i++) perm[i] = i;
                for (int i = n - 1; i > 0; i--) begin
                    int j, tmp;
                    j = $urandom_range(0, i);
                    tmp = perm[i];
                    perm[i] = perm[j];
                    perm[j] = tmp;
                end
                for (int i = 0; i < n; i++) begin
                    int d;
                    d = (perm[i] - i + n) % n;
                    while (d + n <= 7 && $urandom_range(0, 1) == 1) d += n;
                    pat.push_back(d);
                end
            end else begin
                for (int i = 0; i < n; i++) pat.push_back($urandom_range(0, 7));
            end
            load_pattern();
            commit_and_check(ok);
            if (ok) run_beats(2 * n + 8, nb);
            do_clear();
        end
    endtask

    initial begin
        test_reset();
        test_fixed('{5, 3, 1}, 9, 3);
        test_fixed('{4, 4, 1, 3}, 12, 3);
        test_fixed('{3, 0, 0}, 9, 1);
        test_error_pattern();
        test_boundaries();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
